// File: rtl/mul_pipe_unit.sv
// mul_pipe_unit: fully pipelined WIDTHxWIDTH multiplier with valid/ready handshakes, op tag and sync flush.
// The product is formed at entry and carried through LAT stages under a global stall.
module mul_pipe_unit #(
  parameter int WIDTH = 16,
  parameter int LAT   = 2,
  parameter int ID_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_signed,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [ID_W-1:0]            in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WIDTH-1:0]         out_prod,
  output logic [ID_W-1:0]            out_tag,
  output logic                       busy,
  output logic [$clog2(LAT+1)-1:0]   inflight
);
  localparam int CW = $clog2(LAT+1);
  logic                 w_adv, w_acc, w_hs;
  logic [2*WIDTH-1:0]   w_ea, w_eb, w_prod;
  logic [LAT-1:0]       r_vld;
  logic [2*WIDTH-1:0]   r_prod [LAT];
  logic [ID_W-1:0]      r_tag  [LAT];
  logic [CW-1:0]        r_cnt;
  assign out_valid = r_vld[LAT-1];
  assign out_prod  = r_prod[LAT-1];
  assign out_tag   = r_tag[LAT-1];
  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv && !flush;
  assign w_acc     = in_valid && in_ready;
  assign w_hs      = out_valid && out_ready;
  assign inflight  = r_cnt;
  assign busy      = r_cnt != '0;
  // Extending to 2*WIDTH first makes the truncated product exact for both signed and unsigned operands.
  assign w_ea   = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
  assign w_eb   = in_signed ? {{WIDTH{in_b[WIDTH-1]}}, in_b} : {{WIDTH{1'b0}}, in_b};
  assign w_prod = w_ea * w_eb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_cnt <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_prod[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else begin
      if (flush) r_vld <= '0;
      else if (w_adv) r_vld <= LAT'({r_vld, w_acc});
      // Payloads only move behind a valid op so out_prod/out_tag keep the last result when idle.
      if (w_adv && !flush) begin
        if (w_acc) begin
          r_prod[0] <= w_prod;
          r_tag[0]  <= in_tag;
        end
        for (int i = 1; i < LAT; i++) begin
          if (r_vld[i-1]) begin
            r_prod[i] <= r_prod[i-1];
            r_tag[i]  <= r_tag[i-1];
          end
        end
      end
      r_cnt <= flush ? '0 : r_cnt + CW'(w_acc) - CW'(w_hs);
    end
  end
endmodule

// File: tb/tb_mul_pipe_unit.sv
// tb_mul_pipe_unit: directed scenarios on a WIDTH=16/LAT=2 unit plus a random stream
// driven into WIDTH=8/LAT=1 and WIDTH=32/LAT=4 units, checked against an arithmetic model.
module tb_mul_pipe_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail  = 0;
  logic flush, iv, is, ordy, ir, ov, busy;
  logic [15:0] ia, ib;
  logic [3:0]  itag, otag;
  logic [31:0] op;
  logic [1:0]  infl;
  mul_pipe_unit #(.WIDTH(16), .LAT(2), .ID_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv), .in_ready(ir), .in_signed(is),
    .in_a(ia), .in_b(ib), .in_tag(itag), .out_valid(ov), .out_ready(ordy), .out_prod(op),
    .out_tag(otag), .busy(busy), .inflight(infl));
  logic x_flush, x_iv, x_is, x_ordy;
  logic [31:0] x_a, x_b;
  logic [3:0]  x_tag;
  logic ir8, ov8, busy8, ir32, ov32, busy32;
  logic [15:0] op8;
  logic [63:0] op32;
  logic [3:0]  ot8, ot32;
  logic [0:0]  in8;
  logic [2:0]  in32;
  mul_pipe_unit #(.WIDTH(8), .LAT(1), .ID_W(4)) u_w8 (
    .clk(clk), .rst_n(rst_n), .flush(x_flush), .in_valid(x_iv), .in_ready(ir8), .in_signed(x_is),
    .in_a(x_a[7:0]), .in_b(x_b[7:0]), .in_tag(x_tag), .out_valid(ov8), .out_ready(x_ordy),
    .out_prod(op8), .out_tag(ot8), .busy(busy8), .inflight(in8));
  mul_pipe_unit #(.WIDTH(32), .LAT(4), .ID_W(4)) u_w32 (
    .clk(clk), .rst_n(rst_n), .flush(x_flush), .in_valid(x_iv), .in_ready(ir32), .in_signed(x_is),
    .in_a(x_a), .in_b(x_b), .in_tag(x_tag), .out_valid(ov32), .out_ready(x_ordy),
    .out_prod(op32), .out_tag(ot32), .busy(busy32), .inflight(in32));
  typedef struct packed { logic [63:0] p; logic [3:0] t; } exp_t;
  exp_t q8[$];
  exp_t q32[$];
  function automatic logic [63:0] refm(int w, bit s, longint unsigned a, longint unsigned b);
    longint sa, sb, p;
    sa = (s && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = (s && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
    p = sa * sb;
    if (2 * w < 64) p = p & ((longint'(1) << (2 * w)) - 1);
    return p;
  endfunction
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({ov, op, otag, busy, infl} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b p=%h t=%0d busy=%0b infl=%0d, want all 0", ov, op, otag, busy, infl);
    end
    nxt();
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    iv = 1'b1; is = 1'b0; ia = 16'h1234; ib = 16'h0010; itag = 4'd3; ordy = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ir !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %0b want 1", ir); end
    nxt();
    iv = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ov, infl, busy} !== {1'b0, 2'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_n1: got v=%0b infl=%0d busy=%0b want v=0 infl=1 busy=1", ov, infl, busy);
    end
    nxt();
    @(negedge clk);
    n_tests++;
    if ({ov, op, otag} !== {1'b1, 32'h0001_2340, 4'd3}) begin
      n_fail++;
      $display("FAIL basic_result: got v=%0b p=%h t=%0d want v=1 p=00012340 t=3", ov, op, otag);
    end
    nxt();
    @(negedge clk);
    n_tests++;
    if ({ov, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_pulse: got v=%0b busy=%0b want 0 0", ov, busy); end
    nxt();
  endtask
  task automatic test_signed();
    bit          s[3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] a[3] = '{16'hFFFF, 16'hFFFF, 16'h8000};
    logic [15:0] b[3] = '{16'h0002, 16'h0002, 16'h8000};
    logic [31:0] e[3] = '{32'hFFFF_FFFE, 32'h0001_FFFE, 32'h4000_0000};
    for (int i = 0; i < 3; i++) begin
      iv = 1'b1; is = s[i]; ia = a[i]; ib = b[i]; itag = 4'(i);
      nxt();
      iv = 1'b0;
      nxt();
      @(negedge clk);
      n_tests++;
      if ({ov, op, otag} !== {1'b1, e[i], 4'(i)}) begin
        n_fail++;
        $display("FAIL signed_%0d: got v=%0b p=%h t=%0d want v=1 p=%h t=%0d", i, ov, op, otag, e[i], i);
      end
      nxt();
    end
  endtask
  task automatic test_back_to_back();
    logic [15:0] a[5], b[5];
    bit          s[5];
    logic [31:0] e[5];
    int peak = 0;
    for (int i = 0; i < 5; i++) begin
      a[i] = 16'($urandom); b[i] = 16'($urandom); s[i] = 1'($urandom);
      e[i] = 32'(refm(16, s[i], a[i], b[i]));
    end
    ordy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      iv = c < 5;
      if (c < 5) begin ia = a[c]; ib = b[c]; is = s[c]; itag = 4'(c); end
      @(negedge clk);
      n_tests++;
      if (c >= 2 && c <= 6) begin
        if ({ov, op, otag} !== {1'b1, e[c-2], 4'(c-2)}) begin
          n_fail++;
          $display("FAIL b2b_c%0d: got v=%0b p=%h t=%0d want v=1 p=%h t=%0d", c, ov, op, otag, e[c-2], c-2);
        end
      end else if (ov !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_c%0d: got v=%0b want v=0", c, ov);
      end
      if (int'(infl) > peak) peak = int'(infl);
      nxt();
    end
    iv = 1'b0;
    n_tests++;
    if (peak != 2) begin n_fail++; $display("FAIL b2b_peak_inflight: got %0d want 2", peak); end
  endtask
  task automatic test_stall();
    logic [15:0] a0, b0, a1, b1;
    logic [31:0] e0, e1;
    a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
    e0 = 32'(refm(16, 1'b1, a0, b0)); e1 = 32'(refm(16, 1'b0, a1, b1));
    for (int c = 0; c < 8; c++) begin
      iv = c <= 4; ordy = !(c >= 2 && c <= 4);
      is = c == 0; ia = c == 0 ? a0 : c == 1 ? a1 : 16'h7777; ib = c == 0 ? b0 : c == 1 ? b1 : 16'h3333;
      itag = c == 0 ? 4'd5 : c == 1 ? 4'd6 : 4'd7;
      @(negedge clk);
      n_tests++;
      if (c >= 2 && c <= 4) begin
        if ({ov, op, otag, ir, infl} !== {1'b1, e0, 4'd5, 1'b0, 2'd2}) begin
          n_fail++;
          $display("FAIL stall_c%0d: got v=%0b p=%h t=%0d rdy=%0b infl=%0d want v=1 p=%h t=5 rdy=0 infl=2",
                   c, ov, op, otag, ir, infl, e0);
        end
      end else if (c == 5 || c == 6) begin
        if ({ov, op, otag} !== {1'b1, c == 5 ? e0 : e1, c == 5 ? 4'd5 : 4'd6}) begin
          n_fail++;
          $display("FAIL stall_release_c%0d: got v=%0b p=%h t=%0d want v=1 p=%h t=%0d",
                   c, ov, op, otag, c == 5 ? e0 : e1, c == 5 ? 5 : 6);
        end
      end else if (ov !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_c%0d: got v=%0b want v=0", c, ov);
      end
      nxt();
    end
  endtask
  task automatic test_flush();
    ordy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      iv = c <= 2; flush = c == 2; ordy = c != 2;
      ia = 16'(c + 3); ib = 16'h0101; is = 1'b0; itag = 4'(8 + c);
      @(negedge clk);
      n_tests++;
      if (c == 2) begin
        if ({ir, infl} !== {1'b0, 2'd2}) begin
          n_fail++;
          $display("FAIL flush_cycle: got rdy=%0b infl=%0d want rdy=0 infl=2", ir, infl);
        end
      end else if (c >= 3) begin
        if ({ov, infl, busy} !== 4'b0) begin
          n_fail++;
          $display("FAIL flush_after_c%0d: got v=%0b t=%0d infl=%0d busy=%0b want v=0 infl=0 busy=0",
                   c, ov, otag, infl, busy);
        end
      end else if (ir !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_issue_c%0d: got rdy=%0b want 1", c, ir);
      end
      nxt();
      flush = 1'b0;
    end
    iv = 1'b0;
  endtask
  task automatic test_async_reset();
    ordy = 1'b1;
    for (int c = 0; c < 2; c++) begin
      iv = 1'b1; ia = 16'h00F0 + 16'(c); ib = 16'h0011; is = 1'b0; itag = 4'(1 + c);
      nxt();
    end
    iv = 1'b0;
    #2;
    n_tests++;
    if ({ov, busy} !== 2'b11) begin n_fail++; $display("FAIL areset_pre: got v=%0b busy=%0b want 1 1", ov, busy); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ov, op, otag, busy, infl} !== '0) begin
      n_fail++;
      $display("FAIL areset_clear: got v=%0b p=%h t=%0d busy=%0b infl=%0d want all 0", ov, op, otag, busy, infl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      nxt();
      @(negedge clk);
      n_tests++;
      if ({ov, busy} !== 2'b00) begin n_fail++; $display("FAIL areset_after_c%0d: got v=%0b busy=%0b want 0 0", c, ov, busy); end
    end
    nxt();
  endtask
  task automatic test_random();
    for (int cyc = 0; cyc < 420; cyc++) begin
      bit drain;
      drain = cyc >= 400;
      x_iv = !drain && $urandom_range(0, 3) != 0;
      x_flush = !drain && $urandom_range(0, 39) == 0;
      x_ordy = drain || $urandom_range(0, 3) != 0;
      x_is = 1'($urandom); x_tag = 4'($urandom);
      x_a = $urandom; x_b = $urandom;
      case ($urandom_range(0, 7))
        0: x_a = 32'h0;
        1: x_a = 32'hFFFF_FFFF;
        2: x_b = 32'h8000_0080;
        default: ;
      endcase
      @(negedge clk);
      n_tests++;
      if (int'(in8) != q8.size() || int'(in32) != q32.size()) begin
        n_fail++;
        $display("FAIL rand_inflight_cyc%0d: got w8=%0d w32=%0d want w8=%0d w32=%0d", cyc, in8, in32, q8.size(), q32.size());
      end
      if (ov8 && x_ordy) begin
        n_tests++;
        if (q8.size() == 0 || {op8, ot8} !== {q8[0].p[15:0], q8[0].t}) begin
          n_fail++;
          $display("FAIL rand_w8_cyc%0d: got p=%h t=%0d want p=%h t=%0d (queued %0d)",
                   cyc, op8, ot8, q8.size() ? q8[0].p[15:0] : 16'h0, q8.size() ? q8[0].t : 4'h0, q8.size());
        end
        if (q8.size() != 0) void'(q8.pop_front());
      end
      if (ov32 && x_ordy) begin
        n_tests++;
        if (q32.size() == 0 || {op32, ot32} !== {q32[0].p, q32[0].t}) begin
          n_fail++;
          $display("FAIL rand_w32_cyc%0d: got p=%h t=%0d want p=%h t=%0d (queued %0d)",
                   cyc, op32, ot32, q32.size() ? q32[0].p : 64'h0, q32.size() ? q32[0].t : 4'h0, q32.size());
        end
        if (q32.size() != 0) void'(q32.pop_front());
      end
      if (x_flush) begin
        q8.delete();
        q32.delete();
      end else begin
        if (x_iv && ir8) q8.push_back('{refm(8, x_is, x_a[7:0], x_b[7:0]), x_tag});
        if (x_iv && ir32) q32.push_back('{refm(32, x_is, x_a, x_b), x_tag});
      end
      nxt();
    end
    @(negedge clk);
    n_tests++;
    if (q8.size() != 0 || q32.size() != 0 || {ov8, ov32} !== 2'b00) begin
      n_fail++;
      $display("FAIL rand_drain: got pending w8=%0d w32=%0d v8=%0b v32=%0b want all 0", q8.size(), q32.size(), ov8, ov32);
    end
  endtask
  initial begin
    rst_n = 1'b0; flush = 1'b0; iv = 1'b0; is = 1'b0; ia = '0; ib = '0; itag = '0; ordy = 1'b1;
    x_flush = 1'b0; x_iv = 1'b0; x_is = 1'b0; x_ordy = 1'b1; x_a = '0; x_b = '0; x_tag = '0;
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
